// File: rtl/imm_enc_pkg.sv
// Shared immediate-format definitions for the immediate encoder and imm_gen.
package imm_pkg;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_U = 3'b010;
   localparam logic [2:0] IMM_B = 3'b101;
   localparam logic [2:0] IMM_J = 3'b110;

   typedef struct packed {
      logic [2:0]  src;
      logic [31:0] val;
      logic [31:0] base;
   } immPayload_t;

endpackage

// File: rtl/imm_enc_if.sv
// Handshake/data bundle between the program loader and imm_enc.
// RtMismatch is present only when IMM_ENC_ROUNDTRIP_CHK_EN is defined.
interface imm_enc_if #(parameter int unsigned ERRCNT_W = 8);

   logic                in_valid;
   logic                in_ready;
   logic [2:0]          ImmSrc;
   logic [31:0]         ImmVal;
   logic [31:0]         Base;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         Instr;
   logic                ErrRange;
   logic                ErrAlign;
   logic                ErrSrc;
   logic [ERRCNT_W-1:0] ErrCnt;
`ifdef IMM_ENC_ROUNDTRIP_CHK_EN
   logic                RtMismatch;
`endif

   modport master (
`ifdef IMM_ENC_ROUNDTRIP_CHK_EN
      input  RtMismatch,
`endif
      output in_valid, ImmSrc, ImmVal, Base, out_ready,
      input  in_ready, out_valid, Instr, ErrRange, ErrAlign, ErrSrc, ErrCnt
   );

   modport slave (
`ifdef IMM_ENC_ROUNDTRIP_CHK_EN
      output RtMismatch,
`endif
      input  in_valid, ImmSrc, ImmVal, Base, out_ready,
      output in_ready, out_valid, Instr, ErrRange, ErrAlign, ErrSrc, ErrCnt
   );

endinterface

// File: rtl/imm_enc_check.sv
// Range/alignment/format legality of an immediate for a given ImmSrc.
import imm_pkg::*;

module imm_enc_check (
   input  logic [2:0]  ImmSrc,
   input  logic [31:0] ImmVal,
   output logic        ErrRange,
   output logic        ErrAlign,
   output logic        ErrSrc
);

   always_comb begin
      ErrRange = 1'b0;
      ErrAlign = 1'b0;
      ErrSrc   = 1'b0;
      // Range test: the bits above the format's sign bit must all equal it.
      case (ImmSrc)
         IMM_I, IMM_S: ErrRange = !((&ImmVal[31:11]) || !(|ImmVal[31:11]));
         IMM_B: begin
            ErrRange = !((&ImmVal[31:12]) || !(|ImmVal[31:12]));
            ErrAlign = ImmVal[0];
         end
         IMM_J: begin
            ErrRange = !((&ImmVal[31:20]) || !(|ImmVal[31:20]));
            ErrAlign = ImmVal[0];
         end
         IMM_U:   ErrAlign = |ImmVal[11:0];
         default: ErrSrc = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder: scatters an immediate into a template RV32I instruction, 2-stage pipe.
// Optional round-trip self-check via imm_gen when IMM_ENC_ROUNDTRIP_CHK_EN is defined.
import imm_pkg::*;

module imm_enc #(
   parameter int unsigned ERRCNT_W = 8
) (
   input logic     clk,
   input logic     rst_n,
   imm_enc_if.slave bus
);

   logic                s1Valid;
   logic                s1Ready;
   immPayload_t         s1Pay;
   logic                s2Valid;
   logic                s2Ready;
   logic [31:0]         s2Instr;
   logic                s2Range;
   logic                s2Align;
   logic                s2Src;
   logic [ERRCNT_W-1:0] errCnt;
   logic                chkRange;
   logic                chkAlign;
   logic                chkSrc;
   logic [31:0]         instrNext;
   logic                anyErr;

   assign s2Ready     = !s2Valid || bus.out_ready;
   assign s1Ready     = !s1Valid || s2Ready;
   assign bus.in_ready = s1Ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid <= 1'b0;
         s1Pay   <= '0;
      end else if (s1Ready) begin
         s1Valid <= bus.in_valid;
         if (bus.in_valid) s1Pay <= '{src: bus.ImmSrc, val: bus.ImmVal, base: bus.Base};
      end
   end

   imm_enc_check u_check (
      .ImmSrc   (s1Pay.src),
      .ImmVal   (s1Pay.val),
      .ErrRange (chkRange),
      .ErrAlign (chkAlign),
      .ErrSrc   (chkSrc)
   );

   always_comb begin
      instrNext = s1Pay.base;
      case (s1Pay.src)
         IMM_I: instrNext[31:20] = s1Pay.val[11:0];
         IMM_S: begin
            instrNext[31:25] = s1Pay.val[11:5];
            instrNext[11:7]  = s1Pay.val[4:0];
         end
         IMM_B: begin
            instrNext[31]    = s1Pay.val[12];
            instrNext[30:25] = s1Pay.val[10:5];
            instrNext[11:8]  = s1Pay.val[4:1];
            instrNext[7]     = s1Pay.val[11];
         end
         IMM_U: instrNext[31:12] = s1Pay.val[31:12];
         IMM_J: begin
            instrNext[31]    = s1Pay.val[20];
            instrNext[30:21] = s1Pay.val[10:1];
            instrNext[20]    = s1Pay.val[11];
            instrNext[19:12] = s1Pay.val[19:12];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2Valid <= 1'b0;
         s2Instr <= '0;
         s2Range <= 1'b0;
         s2Align <= 1'b0;
         s2Src   <= 1'b0;
      end else if (s2Ready) begin
         s2Valid <= s1Valid;
         if (s1Valid) begin
            s2Instr <= instrNext;
            s2Range <= chkRange;
            s2Align <= chkAlign;
            s2Src   <= chkSrc;
         end
      end
   end

   assign anyErr = s2Range || s2Align || s2Src;

   // Saturating: hold at all-ones rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errCnt <= '0;
      end else if (s2Valid && bus.out_ready && anyErr && (errCnt != '1)) begin
         errCnt <= errCnt + 1'b1;
      end
   end

   assign bus.out_valid = s2Valid;
   assign bus.Instr     = s2Instr;
   assign bus.ErrRange  = s2Range;
   assign bus.ErrAlign  = s2Align;
   assign bus.ErrSrc    = s2Src;
   assign bus.ErrCnt    = errCnt;

`ifdef IMM_ENC_ROUNDTRIP_CHK_EN
   logic [2:0]  s2ImmSrc;
   logic [31:0] s2ImmVal;
   logic [31:0] immExt;
   logic [31:0] immWant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2ImmSrc <= '0;
         s2ImmVal <= '0;
      end else if (s2Ready && s1Valid) begin
         s2ImmSrc <= s1Pay.src;
         s2ImmVal <= s1Pay.val;
      end
   end

   imm_gen u_gen (
      .Instr  (s2Instr[31:7]),
      .ImmSrc (s2ImmSrc),
      .ImmExt (immExt)
   );

   assign immWant        = (s2ImmSrc == IMM_U) ? {s2ImmVal[31:12], 12'b0} : s2ImmVal;
   assign bus.RtMismatch = s2Valid && !anyErr && (immExt != immWant);
`endif

endmodule

// File: tb/tb_imm_enc.sv
// Directed-vector bench for imm_enc: formats, errors, backpressure, saturation, async reset.
module tb_imm_enc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nVec = 0;
   int   nBad = 0;

   always #5 clk = ~clk;

   imm_enc_if #(.ERRCNT_W(8)) bus ();

   imm_enc #(.ERRCNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One isolated beat: accept, check 2-cycle latency, fields, flags, then ErrCnt after the handshake.
   task automatic doBeat(input string tag, input logic [2:0] src, input logic [31:0] val,
                         input logic [31:0] base, input logic [31:0] expInstr,
                         input logic [2:0] expErr, input logic [31:0] expCnt);
      @(negedge clk);
      bus.ImmSrc    = src;
      bus.ImmVal    = val;
      bus.Base      = base;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk({tag, "_inrdy"}, bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, "_lat1"}, bus.out_valid, 0);
      @(negedge clk);
      chk({tag, "_ovalid"}, bus.out_valid, 1);
      chk({tag, "_instr"}, bus.Instr, expInstr);
      chk({tag, "_err"}, {bus.ErrRange, bus.ErrAlign, bus.ErrSrc}, expErr);
      @(negedge clk);
      chk({tag, "_cnt"}, bus.ErrCnt, expCnt);
      chk({tag, "_drain"}, bus.out_valid, 0);
   endtask

   function automatic logic [31:0] bpInstr(input int i);
      return (32'(i + 1) << 20) | 32'h13;
   endfunction

   initial begin
      int idx;
      int got;
      int n;
      logic acc;
      logic hs;
      logic held;
      logic [31:0] hold;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.ImmSrc    = '0;
      bus.ImmVal    = '0;
      bus.Base      = '0;

      #12;
      chk("rst_ovalid", bus.out_valid, 0);
      chk("rst_instr", bus.Instr, 0);
      chk("rst_err", {bus.ErrRange, bus.ErrAlign, bus.ErrSrc}, 0);
      chk("rst_cnt", bus.ErrCnt, 0);
      chk("rst_inrdy", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      doBeat("I",    3'b000, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 3'b000, 0);
      doBeat("S",    3'b001, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 3'b000, 0);
      doBeat("B",    3'b101, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 3'b000, 0);
      doBeat("U",    3'b010, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 3'b000, 0);
      doBeat("J",    3'b110, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 3'b000, 0);
      doBeat("Irng", 3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 3'b100, 1);
      doBeat("Baln", 3'b101, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 3'b010, 2);
      doBeat("Src",  3'b111, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 3'b001, 3);

      // Backpressure: out_ready low for 5 cycles while three I-beats are offered.
      bus.out_ready = 1'b0;
      idx  = 0;
      got  = 0;
      held = 1'b0;
      hold = '0;
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
         @(negedge clk);
         if (cyc == 5) bus.out_ready = 1'b1;
         if (idx < 3) begin
            bus.ImmSrc   = 3'b000;
            bus.ImmVal   = 32'(idx + 1);
            bus.Base     = 32'h13;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (cyc == 4) begin
            chk("bp_accepted", idx, 2);
            chk("bp_inrdy", bus.in_ready, 0);
         end
         if (bus.out_valid && !bus.out_ready) begin
            if (!held) begin
               hold = bus.Instr;
               held = 1'b1;
            end else begin
               chk("bp_hold", bus.Instr, hold);
            end
         end
         acc = bus.in_valid && bus.in_ready;
         hs  = bus.out_valid && bus.out_ready;
         if (hs) begin
            chk("bp_order", bus.Instr, bpInstr(got));
            got++;
         end
         @(posedge clk);
         if (acc) idx++;
      end
      chk("bp_count", got, 3);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_nodup", bus.out_valid, 0);
      chk("bp_cnt", bus.ErrCnt, 3);

      // Saturation: stream 260 illegal-format beats at full rate.
      bus.ImmSrc    = 3'b111;
      bus.ImmVal    = '0;
      bus.Base      = '0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 400 && n < 260; cyc++) begin
         @(negedge clk);
         hs = bus.out_valid && bus.out_ready;
         @(posedge clk);
         if (hs) n++;
      end
      chk("sat_beats", n, 260);
      @(negedge clk);
      chk("sat_cnt", bus.ErrCnt, 255);
      chk("pre_rst_ovalid", bus.out_valid, 1);

      // Asynchronous reset between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ovalid", bus.out_valid, 0);
      chk("arst_cnt", bus.ErrCnt, 0);
      chk("arst_instr", bus.Instr, 0);
      chk("arst_inrdy", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ovalid1", bus.out_valid, 0);
      @(negedge clk);
      chk("post_rst_ovalid2", bus.out_valid, 0);
      chk("post_rst_cnt", bus.ErrCnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
